// File: rtl/pwm2throttle_if.sv
// rtl/pwm2throttle_if.sv - decoded throttle result bus from the PWM receiver
interface pwm2throttle_if;
    logic [7:0]  throttle_setting;
    logic [11:0] pulse_time_us;
    logic        idle;
    logic        valid;
    logic        pulse_error;
    logic        signal_lost;

    modport master (
        output throttle_setting,
        output pulse_time_us,
        output idle,
        output valid,
        output pulse_error,
        output signal_lost
    );

    modport slave (
        input throttle_setting,
        input pulse_time_us,
        input idle,
        input valid,
        input pulse_error,
        input signal_lost
    );
endinterface

// File: rtl/pwm2throttle.sv
// rtl/pwm2throttle.sv - measures RC/ESC PWM high time in us and decodes it to an 8-bit throttle
module pwm2throttle #(
    parameter int CLKS_PER_US  = 27,
    parameter int IDLE_MAX_US  = 1000,
    parameter int MIN_VALID_US = 800,
    parameter int MAX_VALID_US = 2200,
    parameter int TIMEOUT_US   = 25000
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  pwm_in,
    pwm2throttle_if.master        res_o
);

    localparam int              PW       = (CLKS_PER_US > 1) ? $clog2(CLKS_PER_US) : 1;
    localparam logic [PW-1:0]   PS_LAST  = PW'(CLKS_PER_US - 1);
    localparam logic [14:0]     TO_LAST  = 15'(TIMEOUT_US - 1);
    localparam logic [11:0]     IDLE_W   = 12'(IDLE_MAX_US);
    localparam logic [11:0]     MIN_W    = 12'(MIN_VALID_US);
    localparam logic [11:0]     MAX_W    = 12'(MAX_VALID_US);
    localparam logic [11:0]     ZERO_MAX = 12'd1064;
    localparam logic [11:0]     FULL_MIN = 12'd1864;
    localparam logic [17:0]     NUM_FULL = 18'd204400;

    typedef enum logic [2:0] {
        S_WAIT_RISE,
        S_MEASURE,
        S_CLASSIFY,
        S_DIVIDE,
        S_DONE
    } state_t;

    // The synchronizer is deliberately unreset so a line already high at reset release is not seen as a rise.
    logic sync1_q, sync2_q, prev_q;
    always_ff @(posedge clock) begin
        sync1_q <= pwm_in;
        sync2_q <= sync1_q;
        prev_q  <= sync2_q;
    end

    logic rise, fall;
    assign rise = sync2_q & ~prev_q;
    assign fall = ~sync2_q & prev_q;

    logic [PW-1:0] presc_q, presc_d;
    logic [14:0]   to_cnt_q, to_cnt_d;
    logic          tick, timeout_hit;

    assign tick        = (presc_q == PS_LAST);
    assign presc_d     = (rise || tick) ? '0 : presc_q + 1'b1;
    assign to_cnt_d    = rise ? '0 : ((tick && to_cnt_q != 15'h7FFF) ? to_cnt_q + 15'd1 : to_cnt_q);
    assign timeout_hit = tick && !rise && (to_cnt_q == TO_LAST);

    always_ff @(posedge clock) begin
        if (reset) begin
            presc_q  <= '0;
            to_cnt_q <= '0;
        end else begin
            presc_q  <= presc_d;
            to_cnt_q <= to_cnt_d;
        end
    end

    state_t      state_q;
    logic [11:0] width_q, width_d;
    logic [17:0] num_q, num_calc;
    logic [9:0]  rem_q, rem_nx;
    logic [10:0] rem_sh;
    logic [17:0] quot_nx;
    logic [4:0]  div_cnt_q;
    logic        err_cls_q, idle_cls_q, ge;
    logic [7:0]  throttle_q, thr_nx;
    logic [11:0] ptime_q;
    logic        idle_q, valid_q, perr_q, lost_q;

    assign width_d  = (tick && width_q != 12'hFFF) ? width_q + 12'd1 : width_q;
    assign num_calc = ({6'd0, width_q} - 18'd1064) * 18'd255 + 18'd400;

    // Restoring divide by 800: quotient bits shift into num_q as dividend bits shift out.
    assign rem_sh  = {rem_q, num_q[17]};
    assign ge      = (rem_sh >= 11'd800);
    assign rem_nx  = ge ? 10'(rem_sh - 11'd800) : rem_sh[9:0];
    assign quot_nx = {num_q[16:0], ge};
    assign thr_nx  = (|quot_nx[17:8]) ? 8'hFF : quot_nx[7:0];

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_WAIT_RISE;
            width_q    <= '0;
            num_q      <= '0;
            rem_q      <= '0;
            div_cnt_q  <= '0;
            err_cls_q  <= 1'b0;
            idle_cls_q <= 1'b0;
            throttle_q <= '0;
            ptime_q    <= '0;
            idle_q     <= 1'b1;
            valid_q    <= 1'b0;
            perr_q     <= 1'b0;
            lost_q     <= 1'b1;
        end else begin
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            if (timeout_hit) begin
                state_q    <= S_WAIT_RISE;
                lost_q     <= 1'b1;
                idle_q     <= 1'b1;
                throttle_q <= '0;
            end else begin
                case (state_q)
                    S_WAIT_RISE: begin
                        if (rise) begin
                            state_q <= S_MEASURE;
                            width_q <= '0;
                        end
                    end
                    S_MEASURE: begin
                        width_q <= width_d;
                        if (fall) state_q <= S_CLASSIFY;
                    end
                    S_CLASSIFY: begin
                        err_cls_q  <= (width_q < MIN_W) || (width_q > MAX_W);
                        idle_cls_q <= (width_q <= IDLE_W);
                        if (width_q <= ZERO_MAX)      num_q <= '0;
                        else if (width_q >= FULL_MIN) num_q <= NUM_FULL;
                        else                          num_q <= num_calc;
                        rem_q     <= '0;
                        div_cnt_q <= '0;
                        state_q   <= S_DIVIDE;
                    end
                    S_DIVIDE: begin
                        num_q     <= quot_nx;
                        rem_q     <= rem_nx;
                        div_cnt_q <= div_cnt_q + 5'd1;
                        if (div_cnt_q == 5'd17) begin
                            state_q <= S_DONE;
                            if (err_cls_q) begin
                                perr_q <= 1'b1;
                            end else begin
                                throttle_q <= thr_nx;
                                ptime_q    <= width_q;
                                idle_q     <= idle_cls_q;
                                lost_q     <= 1'b0;
                                valid_q    <= 1'b1;
                            end
                        end
                    end
                    S_DONE: begin
                        state_q <= S_WAIT_RISE;
                    end
                    default: begin
                        state_q <= S_WAIT_RISE;
                    end
                endcase
            end
        end
    end

    assign res_o.throttle_setting = throttle_q;
    assign res_o.pulse_time_us    = ptime_q;
    assign res_o.idle             = idle_q;
    assign res_o.valid            = valid_q;
    assign res_o.pulse_error      = perr_q;
    assign res_o.signal_lost      = lost_q;

endmodule
